// File: rtl/exc_ctrl.sv
// Commit-side exception/interrupt controller.
// Each accepted commit is classified as a retire, a trap (interrupt or
// synchronous exception) or an MRET. The same cycle it raises the matching
// CSR strobes, and for a trap or an MRET it also starts a
// flush -> redirect sequence.
//
// Handshake: a commit transfers in any cycle where commit_valid && commit_ready.
// commit_ready is high only in IDLE. The CSR strobes are combinational from
// that transfer and are valid only in that cycle.
module exc_ctrl #(
  parameter int unsigned XLEN                 = 64,
  parameter int unsigned EXCEPTION_CODE_WIDTH = 4,
  parameter int unsigned VIRTUAL_ADDR_LEN     = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  // commit stage
  input  logic                            commit_valid,
  output logic                            commit_ready,
  input  logic [VIRTUAL_ADDR_LEN-1:0]     commit_pc,
  input  logic                            commit_exception,
  input  logic [EXCEPTION_CODE_WIDTH-1:0] commit_ecause,
  input  logic                            commit_mret,
  // CSR inputs
  input  logic                            eip,
  input  logic                            sip,
  input  logic                            tip,
  input  logic [VIRTUAL_ADDR_LEN-1:0]     trap_vector,
  input  logic [VIRTUAL_ADDR_LEN-1:0]     mret_vector,
  // CSR side-effect strobes
  output logic                            retired,
  output logic                            traped,
  output logic                            mret,
  output logic [VIRTUAL_ADDR_LEN-1:0]     ecp,
  output logic [EXCEPTION_CODE_WIDTH-1:0] trap_cause,
  output logic                            interupt,
  // pipeline control
  output logic                            flush,
  input  logic                            flush_done,
  output logic                            redirect_valid,
  output logic [VIRTUAL_ADDR_LEN-1:0]     redirect_pc,
  // debug view of the sequencing state
  output logic [1:0]                      dbg_state
);

  // The interrupt cause literals are never wider than the CSR data path.
  localparam int unsigned CODE_W = (EXCEPTION_CODE_WIDTH < XLEN) ? EXCEPTION_CODE_WIDTH : XLEN;
  localparam logic [EXCEPTION_CODE_WIDTH-1:0] CAUSE_MEI = EXCEPTION_CODE_WIDTH'(CODE_W'(11));
  localparam logic [EXCEPTION_CODE_WIDTH-1:0] CAUSE_MSI = EXCEPTION_CODE_WIDTH'(CODE_W'(3));
  localparam logic [EXCEPTION_CODE_WIDTH-1:0] CAUSE_MTI = EXCEPTION_CODE_WIDTH'(CODE_W'(7));

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [VIRTUAL_ADDR_LEN-1:0] target_q, target_d;
  logic                        flush_q, flush_d;
  logic                        redirect_valid_q, redirect_valid_d;
  logic [VIRTUAL_ADDR_LEN-1:0] redirect_pc_q, redirect_pc_d;
  logic                        commit_fire;

  assign commit_ready   = (state_q == S_IDLE);
  assign commit_fire    = commit_valid && commit_ready;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign dbg_state      = state_q;

  // Classify the accepted commit, drive the CSR strobes and compute the next state.
  always_comb begin
    retired    = 1'b0;
    traped     = 1'b0;
    mret       = 1'b0;
    ecp        = '0;
    trap_cause = '0;
    interupt   = 1'b0;
    state_d    = state_q;
    target_d   = target_q;
    case (state_q)
      S_IDLE: begin
        if (commit_fire) begin
          if (eip || sip || tip) begin
            // An interrupt wins over any exception or MRET on the same instruction.
            traped     = 1'b1;
            interupt   = 1'b1;
            ecp        = commit_pc;
            trap_cause = eip ? CAUSE_MEI : (sip ? CAUSE_MSI : CAUSE_MTI);
            target_d   = trap_vector;
            state_d    = S_FLUSH;
          end else if (commit_exception) begin
            traped     = 1'b1;
            ecp        = commit_pc;
            trap_cause = commit_ecause;
            target_d   = trap_vector;
            state_d    = S_FLUSH;
          end else if (commit_mret) begin
            mret     = 1'b1;
            retired  = 1'b1;
            target_d = mret_vector;
            state_d  = S_FLUSH;
          end else begin
            retired = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (flush_done) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // The pipeline-control outputs are registered as a decode of the next state.
    flush_d          = (state_d == S_FLUSH);
    redirect_valid_d = (state_d == S_REDIRECT);
    redirect_pc_d    = (state_d == S_REDIRECT) ? target_d : '0;
  end

  // State, redirect target and registered pipeline-control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      target_q         <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      target_q         <= target_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

endmodule
